// File: rtl/mw_stage_buffer.sv
// Elastic MEM->WB stage: a DEPTH-entry circular buffer with a valid/ready handshake on
// both sides. State changes on the falling edge of CLK.
module mw_stage_buffer #(
    parameter int BITS  = 32,
    parameter int RA    = 4,
    parameter int DEPTH = 2,
    parameter int CW    = 16
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         ValidM,
    output logic                         ReadyM,
    input  logic                         FlushM,
    input  logic [BITS-1:0]              ALUOutM,
    input  logic [BITS-1:0]              ReadDataM,
    input  logic [RA-1:0]                WA3M,
    input  logic                         PCSrcM,
    input  logic                         RegWriteM,
    input  logic                         MemtoRegM,
    output logic                         ValidW,
    input  logic                         ReadyW,
    output logic [BITS-1:0]              ALUOutW,
    output logic [BITS-1:0]              ReadDataW,
    output logic [RA-1:0]                WA3W,
    output logic                         PCSrcW,
    output logic                         RegWriteW,
    output logic                         MemtoRegW,
    output logic [$clog2(DEPTH+1)-1:0]   CountW,
    output logic [CW-1:0]                StallCntW
);

    localparam int CNTW = $clog2(DEPTH+1);
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int EW   = 2*BITS + RA + 3;
    localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);
    localparam logic [PW-1:0]   LAST = PW'(DEPTH-1);

    // Handshake: an item moves on a falling edge where its side's valid and ready are
    // both high and FlushM is low. ReadyM depends only on registered occupancy.
    logic [EW-1:0]   mem_q [DEPTH];
    logic [PW-1:0]   wp_q, wp_d;
    logic [PW-1:0]   rp_q, rp_d;
    logic [CNTW-1:0] count_q, count_d;
    logic [CW-1:0]   stall_q, stall_d;
    logic            push;
    logic            pop;
    logic [EW-1:0]   entry_in;
    logic [EW-1:0]   head;

    assign ReadyM   = (count_q != FULL);
    assign ValidW   = (count_q != '0);
    assign push     = ValidM & ReadyM & ~FlushM;
    assign pop      = ValidW & ReadyW & ~FlushM;
    assign entry_in = {ALUOutM, ReadDataM, WA3M, PCSrcM, RegWriteM, MemtoRegM};

    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        stall_d = stall_q;
        if (FlushM) begin
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
        end else begin
            // Modulo-DEPTH wrap so non-power-of-two depths work.
            if (push) wp_d = (wp_q == LAST) ? '0 : wp_q + 1'b1;
            if (pop)  rp_d = (rp_q == LAST) ? '0 : rp_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
        if (ValidW && !ReadyW && (stall_q != '1)) stall_d = stall_q + 1'b1;
    end

    always_ff @(negedge CLK or negedge RESET) begin
        if (!RESET) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            stall_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            stall_q <= stall_d;
            if (push) mem_q[wp_q] <= entry_in;
        end
    end

    // Datapath shows slot rp even when empty; controls are squashed by ValidW.
    assign head      = mem_q[rp_q];
    assign ALUOutW   = head[EW-1 -: BITS];
    assign ReadDataW = head[EW-BITS-1 -: BITS];
    assign WA3W      = head[3 +: RA];
    assign PCSrcW    = head[2] & ValidW;
    assign RegWriteW = head[1] & ValidW;
    assign MemtoRegW = head[0] & ValidW;
    assign CountW    = count_q;
    assign StallCntW = stall_q;

endmodule

// File: doc/mw_stage_buffer.md
# mw_stage_buffer

Parametrised, elastic MEM→WB pipeline stage for the pipelined ARM-subset core, replacing the fixed single-entry MEM/WB register. It carries ALU result, load data, destination register and the write-back control bits (PCSrc, RegWrite, MemtoReg) through a DEPTH-entry buffer. A valid/ready handshake lets the write-back stage stall without losing data. Flush and reset squash architectural side effects by forcing the control bits to zero.

## Interface
Parameters:
- BITS, 32, width of ALUOut/ReadData datapath
- RA, 4, register address width (WA3)
- DEPTH, 2, number of buffer entries, ≥1, need not be a power of two
- CW, 16, width of the saturating stall counter

Ports:
- CLK  in  1  clock; all state updates on the falling edge
- RESET  in  1  asynchronous, active-low reset
- ValidM  in  1  MEM stage presents an instruction
- ReadyM  out  1  buffer can accept (count < DEPTH)
- FlushM  in  1  synchronous squash of buffer and incoming item
- ALUOutM, ReadDataM  in  BITS  MEM datapath
- WA3M  in  RA  destination register
- PCSrcM, RegWriteM, MemtoRegM  in  1  write-back controls
- ValidW  out  1  head entry valid
- ReadyW  in  1  WB stage consumes head
- ALUOutW, ReadDataW  out  BITS  head datapath
- WA3W  out  RA  head destination
- PCSrcW, RegWriteW, MemtoRegW  out  1  head controls, gated by ValidW
- CountW  out  $clog2(DEPTH+1)  occupancy
- StallCntW  out  CW  saturating count of back-pressure edges

## Operation
- Storage: circular buffer of DEPTH entries {ALUOut, ReadData, WA3, PCSrc, RegWrite, MemtoReg}; write pointer wp, read pointer rp, occupancy count.
- ReadyM = (count != DEPTH). It depends on registered state only; there is no combinational path from ReadyW.
- push = ValidM & ReadyM & ~FlushM. Entry is written at wp, and wp advances.
- pop = ValidW & ReadyW & ~FlushM. rp advances.
- Pointer wrap: DEPTH-1 → 0 (modulo DEPTH, not a power-of-two mask).
- count' = count + push − pop. Push and pop on the same edge leave count unchanged, and both pointers advance.
- Flush has highest priority. On a falling edge with FlushM=1: count←0, wp←0, rp←0, and the incoming item is dropped. Storage contents are left unchanged.
- ValidW = (count != 0).
- Datapath outputs: ALUOutW, ReadDataW and WA3W always show slot rp, including when the buffer is empty. This keeps the current WB data-through behaviour.
- Control outputs: PCSrcW, RegWriteW and MemtoRegW equal slot rp's bits AND ValidW, so they are 0 whenever the buffer is empty.
- StallCntW increments by 1 on each falling edge where ValidW=1 and ReadyW=0. It saturates at 2^CW−1 and does not wrap. Flush does not clear it.

## Timing
- Reset (RESET=0, asynchronous) sets count, wp, rp and every storage bit to 0, and sets StallCntW to 0.
- During reset: ValidW=0, ReadyM=1, every W output=0, CountW=0.
- Reset release takes effect at the next falling edge. No handshake is accepted while RESET=0.
- Latency into an empty buffer: an item pushed on falling edge n is visible on the W outputs with ValidW=1 immediately after edge n, giving half-cycle MEM→WB timing.
- Full (count=DEPTH): ReadyM=0, so a same-edge pop does not permit a push. Throughput with ReadyW held high is 1 item/cycle.
- Empty: pop is impossible, and a push alone makes count=1.
- Simultaneous FlushM and push/pop: the flush wins, the result is count=0, and no entry is committed.
- Reset mid-operation discards all entries immediately; it does not wait for a clock edge.

## Test plan
- Reset: assert RESET=0 mid-stream with count=2. ValidW, RegWriteW, PCSrcW and MemtoRegW drop to 0 without a clock edge. CountW=0, ReadyM=1, StallCntW=0.
- Streaming, DEPTH=2, ReadyW=1: push ALUOut 0x10, 0x20, 0x30 on consecutive edges. W shows each value one edge later, CountW stays 1, and StallCntW=0.
- Back-pressure: ReadyW=0, push 0xA (WA3=3) then 0xB (WA3=5). CountW=2, ReadyM=0, and a third push of 0xC is ignored. Raise ReadyW and W yields 0xA then 0xB. After 5 stalled edges, StallCntW=5.
- Wrap, DEPTH=3: 7 pushes and 7 pops interleaved so the pointers wrap twice. Output order matches input order exactly.
- Flush: with count=2 and a push of 0xD (RegWrite=1) on the same edge, assert FlushM. The result is CountW=0, ValidW=0, RegWriteW=0, and 0xD never appears.
- Saturation, CW=4: hold ValidW=1 and ReadyW=0 for 20 edges. StallCntW stops at 15.
